// File: rtl/cpu_multicycle.sv
// Multi-cycle ALU core: FETCH/EXEC/(MUL)/WB FSM against a req/ack instruction memory.
// Optional iterative shift-add multiplier enabled by defining CPU_MUL_EN.
module cpu_multicycle #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_data_i,
  output logic            retire_o,
  output logic            illegal_o,
  output logic            busy_o,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o,
  output logic [2:0]      dbg_state_o
);
  localparam int SHW = $clog2(XLEN);

`ifdef CPU_MUL_EN
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, EXEC = 3'd2, MUL = 3'd3, WB = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, EXEC = 3'd2, WB = 3'd4} state_t;
`endif

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc, res;
  logic [31:0]       ir;
  logic              ill_q;
  logic [XLEN-1:0]   regs [32];

  logic [6:0]        op, f7;
  logic [2:0]        f3;
  logic [4:0]        rd, rs1, rs2;
  logic [XLEN-1:0]   rs1_val, rs2_val, imm, alu_res;
  logic              legal, is_mul;

`ifdef CPU_MUL_EN
  logic [XLEN-1:0]   mcand, mplier;
  logic [SHW-1:0]    mul_cnt;
`endif

  assign op  = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];
  assign imm = {{(XLEN-12){ir[31]}}, ir[31:20]};

  // x0 and indices beyond NUM_REGS always read as zero
  assign rs1_val    = (rs1 != 5'd0 && 32'(rs1) < NUM_REGS) ? regs[rs1] : '0;
  assign rs2_val    = (rs2 != 5'd0 && 32'(rs2) < NUM_REGS) ? regs[rs2] : '0;
  assign dbg_data_o = (dbg_addr_i != 5'd0 && 32'(dbg_addr_i) < NUM_REGS) ? regs[dbg_addr_i] : '0;

  always_comb begin
    legal   = 1'b0;
    is_mul  = 1'b0;
    alu_res = '0;
    if (op == 7'b0110011) begin
      if (f7 == 7'b0000000) begin
        legal = 1'b1;
        case (f3)
          3'b000:  alu_res = rs1_val + rs2_val;
          3'b001:  alu_res = rs1_val << rs2_val[SHW-1:0];
          3'b100:  alu_res = rs1_val ^ rs2_val;
          3'b111:  alu_res = rs1_val & rs2_val;
          default: legal = 1'b0;
        endcase
      end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
        legal   = 1'b1;
        alu_res = rs1_val - rs2_val;
      end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
`ifdef CPU_MUL_EN
        legal  = 1'b1;
        is_mul = 1'b1;
`endif
      end
    end else if (op == 7'b0010011) begin
      if (f3 == 3'b000) begin
        legal   = 1'b1;
        alu_res = rs1_val + imm;
      end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
        legal   = 1'b1;
        alu_res = $signed(rs1_val) >>> ir[20 +: SHW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = FETCH;
      FETCH: if (imem_ack_i) state_nxt = EXEC;
`ifdef CPU_MUL_EN
      EXEC:  state_nxt = is_mul ? MUL : WB;
      MUL:   if (mul_cnt == SHW'(XLEN-1)) state_nxt = WB;
`else
      EXEC:  state_nxt = WB;
`endif
      WB:    state_nxt = start_i ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      res   <= '0;
      ill_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
`ifdef CPU_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
      mul_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: if (imem_ack_i) ir <= imem_data_i;
        EXEC: begin
          res   <= alu_res;
          ill_q <= !legal;
`ifdef CPU_MUL_EN
          mcand   <= rs1_val;
          mplier  <= rs2_val;
          mul_cnt <= '0;
`endif
        end
`ifdef CPU_MUL_EN
        // res accumulates one partial product per cycle
        MUL: begin
          res     <= res + (mplier[0] ? mcand : '0);
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + 1'b1;
        end
`endif
        WB: begin
          if (!ill_q && rd != 5'd0 && 32'(rd) < NUM_REGS) regs[rd] <= res;
          pc <= pc + XLEN'(4);
        end
        default: ;
      endcase
    end
  end

  assign imem_req_o  = (state == FETCH);
  assign imem_addr_o = pc;
  assign retire_o    = (state == WB);
  assign illegal_o   = (state == WB) && ill_q;
  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: instruction memory model, register checks via debug port.
// Build with +define+CPU_MUL_EN to exercise the multiplier configuration.
module tb_cpu_multicycle;
  logic        clk = 1'b0;
  logic        rst_i, start_i, imem_ack_i;
  logic [31:0] imem_data_i, imem_addr_o, dbg_data_o;
  logic        imem_req_o, retire_o, illegal_o, busy_o;
  logic [4:0]  dbg_addr_i;
  logic [2:0]  dbg_state_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];
  int          cyc;
  logic        ill;
  logic [31:0] rv;

  always #5 clk = ~clk;

  cpu_multicycle dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .retire_o(retire_o), .illegal_o(illegal_o), .busy_o(busy_o),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o), .dbg_state_o(dbg_state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    dbg_addr_i = a;
    #1;
    v = dbg_data_o;
  endtask

  task automatic wait_req();
    int guard = 0;
    while (!imem_req_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_wait", {31'b0, imem_req_o}, 32'd1);
  endtask

  // Serve one fetch after wait_n stalled cycles; returns cycles from FETCH entry to WB.
  task automatic run(input logic [31:0] inst, input int wait_n, input logic start_wb,
                     output int cycles, output logic ill_o);
    int guard = 0;
    wait_req();
    check("fetch_addr", imem_addr_o, exp_pc);
    cycles = 1;
    for (int i = 0; i < wait_n; i++) begin
      imem_ack_i  = 1'b0;
      imem_data_i = $urandom;
      check("stall_req", {31'b0, imem_req_o}, 32'd1);
      check("stall_addr", imem_addr_o, exp_pc);
      @(negedge clk);
      cycles++;
    end
    imem_ack_i  = 1'b1;
    imem_data_i = inst;
    @(negedge clk);
    cycles++;
    imem_ack_i  = 1'b0;
    imem_data_i = $urandom;
    while (!retire_o && guard < 100) begin
      @(negedge clk);
      cycles++;
      guard++;
    end
    check("retire_seen", {31'b0, retire_o}, 32'd1);
    ill_o   = illegal_o;
    start_i = start_wb;
    @(negedge clk);
    check("retire_pulse", {31'b0, retire_o}, 32'd0);
    exp_pc = exp_pc + 32'd4;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  logic [31:0] tbl_inst [8];
  logic [4:0]  tbl_rd   [8];
  logic [31:0] tbl_val  [8];

  initial begin
    rst_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0; imem_data_i = '0; dbg_addr_i = '0;
    exp_pc = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_state", {29'b0, dbg_state_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_retire", {31'b0, retire_o}, 32'd0);
    check("rst_illegal", {31'b0, illegal_o}, 32'd0);
    check("rst_pc", imem_addr_o, 32'd0);
    read_reg(5'd1, rv); check("rst_x1", rv, 32'd0);

    // addi x1,x0,5 with zero-wait ack
    start_i = 1'b1;
    run(32'h00500093, 0, 1'b1, cyc, ill);
    check("addi_cycles", cyc, 32'd3);
    check("addi_illegal", {31'b0, ill}, 32'd0);
    read_reg(5'd1, rv); check("addi_x1", rv, 32'd5);

    tbl_inst[0] = 32'h40100133;                          tbl_rd[0] = 5'd2;  tbl_val[0] = 32'hFFFF_FFFB;
    tbl_inst[1] = 32'h40115193;                          tbl_rd[1] = 5'd3;  tbl_val[1] = 32'hFFFF_FFFD;
    tbl_inst[2] = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd5); tbl_rd[2] = 5'd5;  tbl_val[2] = 32'h0000_0000;
    tbl_inst[3] = r_type(7'h00, 5'd1, 5'd1, 3'b001, 5'd6); tbl_rd[3] = 5'd6;  tbl_val[3] = 32'h0000_00A0;
    tbl_inst[4] = r_type(7'h00, 5'd1, 5'd2, 3'b100, 5'd7); tbl_rd[4] = 5'd7;  tbl_val[4] = 32'hFFFF_FFFE;
    tbl_inst[5] = r_type(7'h00, 5'd3, 5'd2, 3'b111, 5'd8); tbl_rd[5] = 5'd8;  tbl_val[5] = 32'hFFFF_FFF9;
    tbl_inst[6] = 32'hFFF00493;                          tbl_rd[6] = 5'd9;  tbl_val[6] = 32'hFFFF_FFFF;
    tbl_inst[7] = r_type(7'h00, 5'd9, 5'd1, 3'b001, 5'd10); tbl_rd[7] = 5'd10; tbl_val[7] = 32'h8000_0000;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl_val[i]);
      run(tbl_inst[i], $urandom_range(0, 2), 1'b1, cyc, ill);
      check("alu_illegal", {31'b0, ill}, 32'd0);
      read_reg(tbl_rd[i], rv);
      check("alu_result", rv, exp_q.pop_front());
    end

    // mul x4,x1,x1
    run(32'h02108233, 0, 1'b1, cyc, ill);
    read_reg(5'd4, rv);
`ifdef CPU_MUL_EN
    check("mul_cycles", cyc, 32'd35);
    check("mul_illegal", {31'b0, ill}, 32'd0);
    check("mul_x4", rv, 32'd25);
`else
    check("mul_cycles", cyc, 32'd3);
    check("mul_illegal", {31'b0, ill}, 32'd1);
    check("mul_x4", rv, 32'd0);
`endif

    // lui x1 (unsupported) and srli x3 (wrong funct7): illegal, no write
    run(32'h123450B7, 0, 1'b1, cyc, ill);
    check("lui_illegal", {31'b0, ill}, 32'd1);
    read_reg(5'd1, rv); check("lui_x1_kept", rv, 32'd5);
    run(32'h00115193, 0, 1'b1, cyc, ill);
    check("srli_illegal", {31'b0, ill}, 32'd1);
    read_reg(5'd3, rv); check("srli_x3_kept", rv, 32'hFFFF_FFFD);

    // addi x0,x0,7: legal, write dropped
    run(32'h00700013, 0, 1'b1, cyc, ill);
    check("x0_illegal", {31'b0, ill}, 32'd0);
    read_reg(5'd0, rv); check("x0_zero", rv, 32'd0);

    // stalled fetch, then stop at WB
    run(32'h00300593, 4, 1'b0, cyc, ill);
    check("stall_cycles", cyc, 32'd7);
    check("idle_state", {29'b0, dbg_state_o}, 32'd0);
    check("idle_busy", {31'b0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    check("idle_pc_held", imem_addr_o, exp_pc);
    check("idle_req", {31'b0, imem_req_o}, 32'd0);
    read_reg(5'd11, rv); check("stall_x11", rv, 32'd3);
    start_i = 1'b1;
    run(32'h00100613, 0, 1'b1, cyc, ill);
    read_reg(5'd12, rv); check("resume_x12", rv, 32'd1);

    // reset while an instruction is in flight
    wait_req();
`ifdef CPU_MUL_EN
    imem_ack_i = 1'b1; imem_data_i = 32'h02108233;
    @(negedge clk);
    imem_ack_i = 1'b0;
    repeat (10) @(negedge clk);
    check("in_mul", {29'b0, dbg_state_o}, 32'd3);
`else
    imem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("in_fetch", {29'b0, dbg_state_o}, 32'd1);
`endif
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    check("mid_rst_state", {29'b0, dbg_state_o}, 32'd0);
    check("mid_rst_req", {31'b0, imem_req_o}, 32'd0);
    check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    check("mid_rst_pc", imem_addr_o, 32'd0);
    for (int r = 0; r < 32; r++) begin
      read_reg(5'(r), rv);
      check("mid_rst_reg", rv, 32'd0);
    end
    exp_pc = '0;
    start_i = 1'b1;
    run(32'h00500093, 0, 1'b1, cyc, ill);
    check("post_rst_cycles", cyc, 32'd3);
    read_reg(5'd1, rv); check("post_rst_x1", rv, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
